ram_sp_arbiter: RTL

Two-requester arbiter and initialiser for the 64x8 single-port RAM. It shares the RAM's single access slot between requester A and requester B, one access per cycle. Both-request ties use last-owner priority capped at `BURST_MAX` consecutive grants. On reset, and on a `clr` pulse, it sweeps every RAM word to zero before granting any access. It sits between the two client blocks and the RAM instance, driving all RAM inputs.

---
 rtl/ram_sp_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter
//   Shares the single access slot of a 2^AW x DW single-port RAM between two
//   requesters (A and B) and zeroes every RAM word after reset or a clr pulse
//   before any access is granted.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   clr                   start a zeroing sweep (sampled each edge)
//   busy                  high while the sweep runs
//   req_x/we_x/addr_x/wdata_x  access request from requester x (a or b)
//   gnt_x                 combinational grant; access completes at an edge
//                         where req_x and gnt_x are both high
//   rvalid_x/rdata_x      read return, one cycle after the granted cycle
//   ram_we, ram_read_addr, ram_write_addr, ram_data   RAM drive
//   ram_q                 RAM registered read data
module ram_sp_arbiter #(
  parameter int DW        = 8,
  parameter int AW        = 6,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          ram_we,
  output logic [AW-1:0] ram_read_addr,
  output logic [AW-1:0] ram_write_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(BURST_MAX);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          last_b;     // 1 = B was the most recent owner, 0 = A
  logic [BW-1:0] burst;
  logic          keep_last;
  logic [DW-1:0] hold_a;
  logic [DW-1:0] hold_b;

  assign busy      = (state == CLEAR);
  assign keep_last = (burst != '0) && (burst < BURST_CAP);

  // Grant selection: a lone requester always wins; a tie goes to the last
  // owner only while its burst is running and below the cap.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == ARB) begin
      if (req_a && req_b) begin
        if (keep_last) begin
          gnt_a = ~last_b;
          gnt_b = last_b;
        end else begin
          gnt_a = last_b;
          gnt_b = ~last_b;
        end
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_comb begin
    ram_we         = 1'b0;
    ram_read_addr  = '0;
    ram_write_addr = '0;
    ram_data       = '0;
    if (state == CLEAR) begin
      ram_we         = 1'b1;
      ram_read_addr  = cnt;
      ram_write_addr = cnt;
    end else if (gnt_a) begin
      ram_we         = we_a;
      ram_read_addr  = addr_a;
      ram_write_addr = addr_a;
      ram_data       = wdata_a;
    end else if (gnt_b) begin
      ram_we         = we_b;
      ram_read_addr  = addr_b;
      ram_write_addr = addr_b;
      ram_data       = wdata_b;
    end
  end

  // Sweep control: cnt wraps to 0 naturally on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (clr) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + AW'(1);
      if (cnt == '1) state <= ARB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
      burst  <= '0;
    end else if (state == ARB) begin
      if (gnt_a || gnt_b) begin
        if (gnt_b == last_b) begin
          if (burst != BURST_CAP) burst <= burst + BW'(1);
        end else begin
          last_b <= gnt_b;
          burst  <= BW'(1);
        end
      end else begin
        burst <= '0;
      end
    end
  end

  // Read return: ram_q already holds the word during the cycle after the
  // granted edge, so rdata passes it through while rvalid is high and the
  // hold register keeps it (captured at the following edge) between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      hold_a   <= '0;
      hold_b   <= '0;
    end else begin
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
      if (rvalid_a) hold_a <= ram_q;
      if (rvalid_b) hold_b <= ram_q;
    end
  end

  assign rdata_a = rvalid_a ? ram_q : hold_a;
  assign rdata_b = rvalid_b ? ram_q : hold_b;

endmodule
